// File: rtl/spi_receive_con.sv
// Main-FPGA receiver for the 4-line camera pixel link: synchronises the link,
// assembles MSB-first nibbles into pixels and tracks their frame coordinates.
module spi_receive_con #(
    parameter int DATA_WIDTH  = 8,
    parameter int LINES       = 4,
    parameter int H_PIXELS    = 160,
    parameter int V_PIXELS    = 90,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [LINES-1:0]             chip_data_in,
    input  logic                         chip_clk_in,
    input  logic                         chip_sel_in,
    input  logic                         frame_sync_in,
    output logic                         pixel_valid_out,
    output logic [DATA_WIDTH-1:0]        pixel_data_out,
    output logic [$clog2(H_PIXELS)-1:0]  hcount_out,
    output logic [$clog2(V_PIXELS)-1:0]  vcount_out,
    output logic                         frame_done_out,
    output logic                         word_error_out
);
    localparam int NIBBLES = DATA_WIDTH / LINES;
    localparam int CW      = $clog2(NIBBLES + 1);
    localparam int HW      = $clog2(H_PIXELS);
    localparam int VW      = $clog2(V_PIXELS);

    localparam logic [CW-1:0] NIB_FULL = CW'(NIBBLES);
    localparam logic [HW-1:0] H_LAST   = HW'(H_PIXELS - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_PIXELS - 1);

    typedef struct packed {
        logic [LINES-1:0] data;
        logic             dclk;
        logic             cs_n;
        logic             fsync;
    } link_t;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    link_t                   pins;
    link_t [SYNC_STAGES-1:0] sync_q;
    link_t                   synced;
    link_t                   hist_q;

    state_t                  state_q;
    logic [CW-1:0]           count_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    armed_q;
    logic                    dclk_rise_q;
    logic                    pixel_valid_q;
    logic [DATA_WIDTH-1:0]   pixel_data_q;
    logic                    frame_done_q;
    logic                    word_error_q;
    logic [HW-1:0]           hcount_q, hcount_d;
    logic [VW-1:0]           vcount_q, vcount_d;

    assign pins   = {chip_data_in, chip_clk_in, chip_sel_in, frame_sync_in};
    assign synced = sync_q[SYNC_STAGES-1];

    // NOTE: the synchroniser and history flops are deliberately left without reset;
    // they flush within SYNC_STAGES+1 cycles and only clean pin values ever reach the FSM.
    always_ff @(posedge clk_in) begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], pins};
        hist_q <= synced;
    end

    // NOTE: every sequential assignment uses <= so all flops update from pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            count_q       <= '0;
            shift_q       <= '0;
            armed_q       <= 1'b0;
            dclk_rise_q   <= 1'b0;
            pixel_valid_q <= 1'b0;
            pixel_data_q  <= '0;
            frame_done_q  <= 1'b0;
            word_error_q  <= 1'b0;
        end else begin
            pixel_valid_q <= 1'b0;
            word_error_q  <= 1'b0;
            dclk_rise_q   <= synced.dclk & ~hist_q.dclk;
            frame_done_q  <= synced.fsync & ~hist_q.fsync;
            // A word may only start once cs has been seen idle after reset.
            if (hist_q.cs_n) armed_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (!hist_q.cs_n && armed_q) begin
                        state_q <= SHIFT;
                        count_q <= '0;
                    end
                end
                SHIFT: begin
                    if (count_q == NIB_FULL) begin
                        pixel_valid_q <= 1'b1;
                        pixel_data_q  <= shift_q;
                        state_q       <= DONE;
                    end else if (hist_q.cs_n) begin
                        word_error_q <= (count_q != '0);
                        state_q      <= IDLE;
                    end else if (dclk_rise_q) begin
                        shift_q <= {shift_q[DATA_WIDTH-LINES-1:0], hist_q.data};
                        count_q <= count_q + CW'(1);
                    end
                end
                DONE: begin
                    if (hist_q.cs_n)      state_q      <= IDLE;
                    else if (dclk_rise_q) word_error_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: next-state values get defaults first so no path can infer a latch.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (frame_done_q) begin
            hcount_d = '0;
            vcount_d = '0;
        end else if (pixel_valid_q) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + VW'(1);
            end else begin
                hcount_d = hcount_q + HW'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign pixel_valid_out = pixel_valid_q;
    assign pixel_data_out  = pixel_data_q;
    assign hcount_out      = hcount_q;
    assign vcount_out      = vcount_q;
    assign frame_done_out  = frame_done_q;
    assign word_error_out  = word_error_q;

endmodule

// File: tb/tb_spi_receive_con.sv
// Bench for spi_receive_con: drives the nibble link and compares strobes, errors and
// coordinates against a pixel-index model (h = n mod H, v = (n / H) mod V).
module tb_spi_receive_con;
    localparam int SS = 2;
    localparam int HP = 160;
    localparam int VP = 90;
    localparam int HS = 4;   // small-frame instance so the row counter wraps quickly
    localparam int VS = 3;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [3:0] chip_data_in = 4'h0;
    logic       chip_clk_in = 1'b0;
    logic       chip_sel_in = 1'b1;
    logic       frame_sync_in = 1'b0;

    logic       pixel_valid_out, frame_done_out, word_error_out;
    logic [7:0] pixel_data_out;
    logic [7:0] hcount_out;
    logic [6:0] vcount_out;
    logic       s_pixel_valid_out, s_frame_done_out, s_word_error_out;
    logic [7:0] s_pixel_data_out;
    logic [1:0] s_hcount_out;
    logic [1:0] s_vcount_out;

    spi_receive_con dut (
        .clk_in(clk_in), .rst_in(rst_in), .chip_data_in(chip_data_in),
        .chip_clk_in(chip_clk_in), .chip_sel_in(chip_sel_in), .frame_sync_in(frame_sync_in),
        .pixel_valid_out(pixel_valid_out), .pixel_data_out(pixel_data_out),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .frame_done_out(frame_done_out), .word_error_out(word_error_out)
    );

    spi_receive_con #(.H_PIXELS(HS), .V_PIXELS(VS)) dut_s (
        .clk_in(clk_in), .rst_in(rst_in), .chip_data_in(chip_data_in),
        .chip_clk_in(chip_clk_in), .chip_sel_in(chip_sel_in), .frame_sync_in(frame_sync_in),
        .pixel_valid_out(s_pixel_valid_out), .pixel_data_out(s_pixel_data_out),
        .hcount_out(s_hcount_out), .vcount_out(s_vcount_out),
        .frame_done_out(s_frame_done_out), .word_error_out(s_word_error_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         h;
        int         v;
        int         c;
    } strobe_t;

    strobe_t got_q[$];
    strobe_t got_s_q[$];
    int      err_cnt = 0;
    int      fd_cnt  = 0;
    int      fd_cyc  = -1;
    int      idx     = 0;
    int      tests_run = 0;
    int      tests_failed = 0;

    always @(negedge clk_in) begin
        if (pixel_valid_out)
            got_q.push_back('{pixel_data_out, int'(hcount_out), int'(vcount_out), cyc});
        if (s_pixel_valid_out)
            got_s_q.push_back('{s_pixel_data_out, int'(s_hcount_out), int'(s_vcount_out), cyc});
        if (word_error_out) err_cnt++;
        if (frame_done_out) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        got_s_q.delete();
        err_cnt = 0;
        fd_cnt  = 0;
        fd_cyc  = -1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick(4);
        rst_in = 1'b0;
        tick(3);
        idx = 0;
        clear_mon();
    endtask

    task automatic nibble(input logic [3:0] d, input int half, input bit fs_mid, output int rise_cyc);
        chip_data_in = d;
        tick(2);
        chip_clk_in = 1'b1;
        rise_cyc = cyc;
        if (fs_mid) begin
            tick(2);
            frame_sync_in = 1'b1;
            tick(half - 2);
        end else begin
            tick(half);
        end
        chip_clk_in = 1'b0;
        tick(half);
    endtask

    task automatic send_word(input logic [7:0] w, input int n_nib, input int half,
                             input bit fs_last, output int last_rise);
        logic [3:0] nib;
        last_rise = 0;
        chip_sel_in = 1'b0;
        tick(4);
        for (int i = 0; i < n_nib; i++) begin
            nib = (i == 0) ? w[7:4] : (i == 1) ? w[3:0] : ~w[3:0];
            nibble(nib, half, fs_last && (i == n_nib - 1), last_rise);
        end
        chip_sel_in = 1'b1;
        tick(6);
        frame_sync_in = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick(5);
        tests_run++;
        if ({pixel_valid_out, pixel_data_out, hcount_out, vcount_out, frame_done_out, word_error_out} !== '0) begin
            tests_failed++;
            $display("FAIL reset_in_reset: outputs=%h required all zero",
                     {pixel_valid_out, pixel_data_out, hcount_out, vcount_out, frame_done_out, word_error_out});
        end
        rst_in = 1'b0;
        clear_mon();
        tick(6);
        tests_run++;
        if ({pixel_valid_out, pixel_data_out, hcount_out, vcount_out} !== '0 || got_q.size() != 0 ||
            err_cnt != 0 || fd_cnt != 0) begin
            tests_failed++;
            $display("FAIL reset_idle: data=%h h=%0d v=%0d strobes=%0d errs=%0d fd=%0d required all zero",
                     pixel_data_out, hcount_out, vcount_out, got_q.size(), err_cnt, fd_cnt);
        end
        idx = 0;
    endtask

    task automatic test_single_word();
        int lr;
        clear_mon();
        send_word(8'hA5, 2, 5, 1'b0, lr);
        tests_run++;
        if (got_q.size() != 1 || err_cnt != 0) begin
            tests_failed++;
            $display("FAIL single_count: strobes=%0d errs=%0d required 1/0", got_q.size(), err_cnt);
        end else begin
            tests_run++;
            if (got_q[0].data !== 8'hA5 || got_q[0].h != 0 || got_q[0].v != 0) begin
                tests_failed++;
                $display("FAIL single_word: data=%h h=%0d v=%0d required a5 0 0",
                         got_q[0].data, got_q[0].h, got_q[0].v);
            end
            tests_run++;
            if (got_q[0].c != lr + SS + 3) begin
                tests_failed++;
                $display("FAIL single_latency: strobe cycle=%0d required %0d", got_q[0].c, lr + SS + 3);
            end
        end
        tests_run++;
        if (pixel_data_out !== 8'hA5 || hcount_out !== 8'd1 || vcount_out !== 7'd0) begin
            tests_failed++;
            $display("FAIL single_hold: data=%h h=%0d v=%0d required a5 1 0",
                     pixel_data_out, hcount_out, vcount_out);
        end
        idx++;
    endtask

    task automatic test_line_wrap();
        int lr;
        do_reset();
        for (int i = 0; i < 161; i++) send_word(8'(i), 2, 3, 1'b0, lr);
        tests_run++;
        if (got_q.size() != 161 || got_s_q.size() != 161) begin
            tests_failed++;
            $display("FAIL line_count: strobes=%0d/%0d required 161", got_q.size(), got_s_q.size());
        end else begin
            for (int i = 0; i < 161; i++) begin
                tests_run++;
                if (got_q[i].data !== 8'(i) || got_q[i].h != i % HP || got_q[i].v != (i / HP) % VP) begin
                    tests_failed++;
                    $display("FAIL line_word%0d: data=%h h=%0d v=%0d required %h %0d %0d", i,
                             got_q[i].data, got_q[i].h, got_q[i].v, 8'(i), i % HP, (i / HP) % VP);
                end
                tests_run++;
                if (got_s_q[i].h != i % HS || got_s_q[i].v != (i / HS) % VS) begin
                    tests_failed++;
                    $display("FAIL small_wrap%0d: h=%0d v=%0d required %0d %0d", i,
                             got_s_q[i].h, got_s_q[i].v, i % HS, (i / HS) % VS);
                end
            end
        end
        idx = 161;
    endtask

    task automatic test_short_word();
        int lr;
        logic [7:0] h0;
        logic [6:0] v0;
        clear_mon();
        h0 = hcount_out;
        v0 = vcount_out;
        send_word(8'h3C, 1, 5, 1'b0, lr);
        tests_run++;
        if (err_cnt != 1 || got_q.size() != 0 || hcount_out !== h0 || vcount_out !== v0) begin
            tests_failed++;
            $display("FAIL short_word: errs=%0d strobes=%0d h=%0d v=%0d required 1 0 %0d %0d",
                     err_cnt, got_q.size(), hcount_out, vcount_out, h0, v0);
        end
    endtask

    task automatic test_extra_edge();
        int lr;
        clear_mon();
        send_word(8'h6E, 3, 5, 1'b0, lr);
        tests_run++;
        if (got_q.size() != 1 || err_cnt != 1) begin
            tests_failed++;
            $display("FAIL extra_count: strobes=%0d errs=%0d required 1/1", got_q.size(), err_cnt);
        end else begin
            tests_run++;
            if (got_q[0].data !== 8'h6E || got_q[0].h != idx % HP || pixel_data_out !== 8'h6E) begin
                tests_failed++;
                $display("FAIL extra_data: data=%h held=%h h=%0d required 6e 6e %0d",
                         got_q[0].data, pixel_data_out, got_q[0].h, idx % HP);
            end
        end
        idx++;
    endtask

    task automatic test_frame_sync();
        int lr;
        do_reset();
        for (int i = 0; i < 36; i++) send_word(8'(i + 7), 2, 3, 1'b0, lr);
        clear_mon();
        send_word(8'hC3, 2, 5, 1'b1, lr);
        tests_run++;
        if (got_q.size() != 1 || fd_cnt != 1) begin
            tests_failed++;
            $display("FAIL fsync_count: strobes=%0d frame_done=%0d required 1/1", got_q.size(), fd_cnt);
        end else begin
            tests_run++;
            if (got_q[0].data !== 8'hC3 || got_q[0].h != 36 || got_q[0].v != 0 || fd_cyc != got_q[0].c) begin
                tests_failed++;
                $display("FAIL fsync_strobe: data=%h h=%0d v=%0d fd_cyc=%0d strobe_cyc=%0d required c3 36 0 same cycle",
                         got_q[0].data, got_q[0].h, got_q[0].v, fd_cyc, got_q[0].c);
            end
        end
        clear_mon();
        send_word(8'h11, 2, 4, 1'b0, lr);
        tests_run++;
        if (got_q.size() != 1 || got_q[0].h != 0 || got_q[0].v != 0 ||
            got_s_q.size() != 1 || got_s_q[0].h != 0 || got_s_q[0].v != 0) begin
            tests_failed++;
            $display("FAIL fsync_next: strobes=%0d required one strobe at h=0 v=0 on both frames", got_q.size());
        end
        idx = 1;
    endtask

    task automatic test_reset_mid_word();
        int lr;
        clear_mon();
        chip_sel_in = 1'b0;
        tick(4);
        nibble(4'h7, 5, 1'b0, lr);
        rst_in = 1'b1;
        tick(3);
        rst_in = 1'b0;
        idx = 0;
        tick(2);
        nibble(4'h1, 5, 1'b0, lr);
        tick(8);
        tests_run++;
        if (got_q.size() != 0 || err_cnt != 0 || hcount_out !== 8'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_word: strobes=%0d errs=%0d h=%0d required 0 0 0",
                     got_q.size(), err_cnt, hcount_out);
        end
        chip_sel_in = 1'b1;
        tick(6);
        send_word(8'h5A, 2, 5, 1'b0, lr);
        tests_run++;
        if (got_q.size() != 1 || got_q[0].data !== 8'h5A || got_q[0].h != 0 || got_q[0].v != 0 || err_cnt != 0) begin
            tests_failed++;
            $display("FAIL rst_recover: strobes=%0d data=%h errs=%0d required 1 5a 0",
                     got_q.size(), pixel_data_out, err_cnt);
        end
        idx = 1;
    endtask

    task automatic test_random();
        int lr, n_nib, half, r, exp_err;
        logic [7:0] w;
        logic [7:0] exp_d[$];
        int exp_i[$];
        int exp_c[$];
        clear_mon();
        exp_err = 0;
        for (int k = 0; k < 60; k++) begin
            w     = 8'($urandom);
            r     = $urandom_range(0, 9);
            n_nib = (r < 6) ? 2 : (r < 8) ? 1 : (r < 9) ? 3 : 0;
            half  = $urandom_range(3, 6);
            send_word(w, n_nib, half, 1'b0, lr);
            if (n_nib >= 2) begin
                exp_d.push_back(w);
                exp_i.push_back(idx);
                exp_c.push_back((n_nib == 2) ? lr + SS + 3 : -1);
                idx++;
            end
            if (n_nib == 1 || n_nib == 3) exp_err++;
            tick($urandom_range(0, 5));
        end
        tests_run++;
        if (got_q.size() != exp_d.size() || got_s_q.size() != exp_d.size() || err_cnt != exp_err) begin
            tests_failed++;
            $display("FAIL rand_count: strobes=%0d/%0d errs=%0d required %0d %0d",
                     got_q.size(), got_s_q.size(), err_cnt, exp_d.size(), exp_err);
        end else begin
            for (int k = 0; k < exp_d.size(); k++) begin
                tests_run++;
                if (got_q[k].data !== exp_d[k] || got_q[k].h != exp_i[k] % HP ||
                    got_q[k].v != (exp_i[k] / HP) % VP || (exp_c[k] >= 0 && got_q[k].c != exp_c[k]) ||
                    got_s_q[k].h != exp_i[k] % HS || got_s_q[k].v != (exp_i[k] / HS) % VS) begin
                    tests_failed++;
                    $display("FAIL rand_word%0d: data=%h h=%0d v=%0d cyc=%0d sh=%0d sv=%0d required %h %0d %0d %0d %0d %0d",
                             k, got_q[k].data, got_q[k].h, got_q[k].v, got_q[k].c, got_s_q[k].h, got_s_q[k].v,
                             exp_d[k], exp_i[k] % HP, (exp_i[k] / HP) % VP, exp_c[k],
                             exp_i[k] % HS, (exp_i[k] / HS) % VS);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_line_wrap();
        test_short_word();
        test_extra_edge();
        test_frame_sync();
        test_reset_mid_word();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
